// File: rtl/lz77_enc_ctrl_pkg.sv
// lz77_pkg: shared types and defaults for the LZ77 encoder controller.
// The token struct is sized for the default index width (TOK_IDX_W).
package lz77_pkg;

    localparam int unsigned SB_LEN    = 9;
    localparam int unsigned MAX_MATCH = 7;
    localparam int unsigned OFF_W     = 4;
    localparam int unsigned LEN_W     = 3;
    localparam int unsigned TOK_IDX_W = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEARCH,
        ST_EMIT,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [OFF_W-1:0]     offset;
        logic [LEN_W-1:0]     len;
        logic [TOK_IDX_W-1:0] char_idx;
    } token_t;

endpackage

// File: rtl/lz77_enc_ctrl_best_match.sv
// lz77_best_match: registered best (len, d) for the current look-ahead
// position. Clips the comparator length to the characters remaining and to
// MAX_MATCH, and replaces the best only on a strictly longer match so that
// ties keep the smaller distance. Next-state values are exported so the
// controller can capture the final token on the last probe cycle.
module lz77_best_match #(
    parameter int unsigned IDX_W     = 12,
    parameter int unsigned LEN_W     = 3,
    parameter int unsigned MAX_MATCH = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_update,
    input  logic [LEN_W-1:0] i_probe_len,
    input  logic [IDX_W-1:0] i_avail,
    input  logic [IDX_W-1:0] i_d,
    output logic [LEN_W-1:0] o_clip_len,
    output logic [LEN_W-1:0] o_len_nxt,
    output logic [IDX_W-1:0] o_d_nxt
);

    logic [LEN_W-1:0] r_len;
    logic [IDX_W-1:0] r_d;
    logic [IDX_W-1:0] w_cap;
    logic [IDX_W-1:0] w_probe_ext;
    logic [LEN_W-1:0] w_clip;
    logic             w_better;

    assign w_cap       = (i_avail < IDX_W'(MAX_MATCH)) ? i_avail : IDX_W'(MAX_MATCH);
    assign w_probe_ext = {{(IDX_W-LEN_W){1'b0}}, i_probe_len};
    assign w_clip      = (w_cap < w_probe_ext) ? w_cap[LEN_W-1:0] : i_probe_len;
    assign w_better    = i_update && (w_clip > r_len);
    assign o_clip_len  = w_clip;

    // Next best: clear wins, otherwise a strictly longer clipped match replaces it.
    always_comb begin
        o_len_nxt = r_len;
        o_d_nxt   = r_d;
        if (i_clear) begin
            o_len_nxt = '0;
            o_d_nxt   = '0;
        end else if (w_better) begin
            o_len_nxt = w_clip;
            o_d_nxt   = i_d;
        end
    end

    // Best-match register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_len <= '0;
            r_d   <= '0;
        end else begin
            r_len <= o_len_nxt;
            r_d   <= o_d_nxt;
        end
    end

endmodule

// File: rtl/lz77_enc_ctrl.sv
// lz77_enc_ctrl: sequencing controller for the LZ77 encoder datapath.
// Loads the string into the external buffer, walks the look-ahead pointer,
// probes one candidate distance per cycle and emits (offset, len, char_idx)
// tokens, pulsing finish after the last one.
// Optional macro LZ77_EARLY_EXIT_EN: stop searching on the first probe that
// reaches the longest achievable length (tokens unchanged, fewer cycles).
module lz77_enc_ctrl #(
    parameter int unsigned SB_LEN    = lz77_pkg::SB_LEN,
    parameter int unsigned MAX_MATCH = lz77_pkg::MAX_MATCH,
    parameter int unsigned IDX_W     = lz77_pkg::TOK_IDX_W,
    parameter int unsigned MAX_LEN   = 2049
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    output logic             buf_we,
    output logic [IDX_W-1:0] buf_waddr,
    output logic [IDX_W-1:0] probe_sb,
    output logic [IDX_W-1:0] probe_lb,
    output logic             probe_valid,
    input  logic [2:0]       probe_len,
    output logic             tok_valid,
    input  logic             tok_ready,
    output logic [3:0]       tok_offset,
    output logic [2:0]       tok_match_len,
    output logic [IDX_W-1:0] tok_char_idx,
    output logic             finish
);

    import lz77_pkg::*;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_n;
    logic [IDX_W-1:0] r_lb;
    logic [IDX_W-1:0] r_d;
    token_t           r_tok;

    logic             w_accept;
    logic [IDX_W-1:0] w_n_inc;
    logic [IDX_W-1:0] w_lim;
    logic [IDX_W-1:0] w_avail;
    logic             w_probe_on;
    logic             w_last_d;
    logic             w_hit;
    logic             w_search_end;
    logic             w_tok_hs;
    logic [IDX_W-1:0] w_lb_adv;
    logic             w_best_clear;
    logic [LEN_W-1:0] w_clip_len;
    logic [LEN_W-1:0] w_len_nxt;
    logic [IDX_W-1:0] w_d_nxt;

    assign in_ready     = ~reset && (r_state == ST_IDLE || r_state == ST_LOAD);
    assign w_accept     = in_valid && in_ready;
    assign buf_we       = w_accept;
    assign buf_waddr    = (r_state == ST_LOAD) ? r_n : '0;

    assign w_n_inc      = r_n + IDX_W'(1);
    assign w_lim        = (r_lb < IDX_W'(SB_LEN)) ? r_lb : IDX_W'(SB_LEN);
    assign w_avail      = r_n - IDX_W'(1) - r_lb;
    assign w_probe_on   = (r_state == ST_SEARCH) && (r_lb != '0);
    assign w_last_d     = (r_d == w_lim);

`ifdef LZ77_EARLY_EXIT_EN
    logic [LEN_W-1:0] w_target;
    assign w_target = (w_avail < IDX_W'(MAX_MATCH)) ? w_avail[LEN_W-1:0] : LEN_W'(MAX_MATCH);
    assign w_hit    = w_probe_on && (w_clip_len == w_target);
`else
    assign w_hit    = 1'b0;
`endif

    assign w_search_end = (r_state == ST_SEARCH) && ((r_lb == '0) || w_last_d || w_hit);
    assign w_tok_hs     = (r_state == ST_EMIT) && tok_ready;
    assign w_lb_adv     = r_lb + IDX_W'(r_tok.len) + IDX_W'(1);
    assign w_best_clear = (r_state != ST_SEARCH);

    assign probe_valid  = w_probe_on;
    assign probe_sb     = w_probe_on ? (r_lb - r_d) : '0;
    assign probe_lb     = (r_state == ST_SEARCH) ? r_lb : '0;

    assign tok_valid     = (r_state == ST_EMIT);
    assign tok_offset    = r_tok.offset;
    assign tok_match_len = r_tok.len;
    assign tok_char_idx  = IDX_W'(r_tok.char_idx);
    assign finish        = (r_state == ST_DONE);

    lz77_best_match #(
        .IDX_W     (IDX_W),
        .LEN_W     (LEN_W),
        .MAX_MATCH (MAX_MATCH)
    ) u_best (
        .clk         (clk),
        .reset       (reset),
        .i_clear     (w_best_clear),
        .i_update    (w_probe_on),
        .i_probe_len (probe_len),
        .i_avail     (w_avail),
        .i_d         (r_d),
        .o_clip_len  (w_clip_len),
        .o_len_nxt   (w_len_nxt),
        .o_d_nxt     (w_d_nxt)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (in_last || MAX_LEN == 1) ? ST_SEARCH : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_accept && (in_last || w_n_inc == IDX_W'(MAX_LEN))) begin
                    w_state_nxt = ST_SEARCH;
                end
            end
            ST_SEARCH: begin
                if (w_search_end) begin
                    w_state_nxt = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (w_tok_hs) begin
                    w_state_nxt = (w_lb_adv >= r_n) ? ST_DONE : ST_SEARCH;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Length, pointers, probe distance and the registered token.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_n   <= '0;
            r_lb  <= '0;
            r_d   <= IDX_W'(1);
            r_tok <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_lb <= '0;
                    r_d  <= IDX_W'(1);
                    if (w_accept) begin
                        r_n <= IDX_W'(1);
                    end
                end
                ST_LOAD: begin
                    r_lb <= '0;
                    r_d  <= IDX_W'(1);
                    if (w_accept) begin
                        r_n <= w_n_inc;
                    end
                end
                ST_SEARCH: begin
                    if (w_search_end) begin
                        r_tok.len      <= w_len_nxt;
                        r_tok.offset   <= (w_len_nxt != '0) ? OFF_W'(w_d_nxt - IDX_W'(1)) : '0;
                        r_tok.char_idx <= TOK_IDX_W'(r_lb + IDX_W'(w_len_nxt));
                    end else begin
                        r_d <= r_d + IDX_W'(1);
                    end
                end
                ST_EMIT: begin
                    if (w_tok_hs) begin
                        r_lb <= w_lb_adv;
                        r_d  <= IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    r_n  <= '0;
                    r_lb <= '0;
                end
                default: begin
                    r_n <= '0;
                end
            endcase
        end
    end

endmodule
